// File: rtl/pipe_reg_chain_pkg.sv
// Shared helpers for the registered valid/ready pipeline.
package pipe_pkg;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_reg_chain_if.sv
// Handshake bundle between producer, pipeline and consumer.
interface pipe_reg_chain_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
);
  logic                                  flush;
  logic                                  in_valid;
  logic [WIDTH-1:0]                      in_data;
  logic                                  in_ready;
  logic                                  out_valid;
  logic [WIDTH-1:0]                      out_data;
  logic                                  out_ready;
  logic [pipe_pkg::cnt_width(DEPTH)-1:0] count;

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/pipe_reg_chain_stage.sv
// One register stage: captures incoming word when advanced, holds otherwise.
module pipe_stage #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             adv,
  input  logic             iv,
  input  logic [WIDTH-1:0] id,
  output logic             v,
  output logic [WIDTH-1:0] d
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= 1'b0;
      d <= RESET_VAL;
    end else if (flush) begin
      v <= 1'b0;
      d <= RESET_VAL;
    end else if (adv) begin
      v <= iv;
      // data only moves with a valid word so idle stages keep their contents
      if (iv) d <= id;
    end
  end

endmodule

// File: rtl/pipe_reg_chain.sv
// Parametrised register chain with bubble-collapsing backpressure, flush and occupancy.
module pipe_reg_chain
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  pipe_reg_chain_if.slave   bus
);

  localparam int CW = cnt_width(DEPTH);

  if (DEPTH < 1) begin : g_bad_depth
    $error("pipe_reg_chain: DEPTH must be at least 1");
  end

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] adv;
  logic [WIDTH-1:0] d [DEPTH];
  logic [CW-1:0]    cnt;

  // Ready ripples combinationally from the output back to stage 0 for full throughput.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = !v[DEPTH-1] | bus.out_ready;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      adv[k] = !v[k] | adv[k+1];
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             iv;
    logic [WIDTH-1:0] id;
    if (k == 0) begin : g_head
      assign iv = bus.in_valid;
      assign id = bus.in_data;
    end else begin : g_body
      assign iv = v[k-1];
      assign id = d[k-1];
    end

    pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk   (clk),
      .rst   (rst),
      .flush (bus.flush),
      .adv   (adv[k]),
      .iv    (iv),
      .id    (id),
      .v     (v[k]),
      .d     (d[k])
    );
  end

  always_comb begin
    cnt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      cnt = cnt + CW'(v[k]);
    end
  end

  assign bus.in_ready  = adv[0] & !bus.flush;
  assign bus.out_valid = v[DEPTH-1] & !bus.flush;
  assign bus.out_data  = d[DEPTH-1];
  assign bus.count     = cnt;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed and scoreboard checks of pipe_reg_chain at DEPTH 3, 1 and 5.
module tb_pipe_reg_chain;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pipe_reg_chain_if #(.WIDTH(8), .DEPTH(3)) b3 ();
  pipe_reg_chain_if #(.WIDTH(8), .DEPTH(1)) b1 ();
  pipe_reg_chain_if #(.WIDTH(8), .DEPTH(5)) b5 ();

  pipe_reg_chain #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'hA5)) u3 (.clk(clk), .rst(rst), .bus(b3));
  pipe_reg_chain #(.WIDTH(8), .DEPTH(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  pipe_reg_chain #(.WIDTH(8), .DEPTH(5)) u5 (.clk(clk), .rst(rst), .bus(b5));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    tick();
    b3.in_valid = 1'b1; b3.in_data = 8'h5A; b3.out_ready = 1'b0;
    tick();
    b3.in_valid = 1'b0;
    tick();
    tick();
    #1;
    checks++;
    if (b3.count !== 2'd1) begin
      failures++; $display("FAIL reset_pre_count: got %0d expected 1", b3.count);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (b3.out_data !== 8'hA5) begin
      failures++; $display("FAIL reset_out_data: got %0h expected a5", b3.out_data);
    end
    checks++;
    if (b3.out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid: got %0b expected 0", b3.out_valid);
    end
    checks++;
    if (b3.count !== 2'd0) begin
      failures++; $display("FAIL reset_count: got %0d expected 0", b3.count);
    end
    checks++;
    if (b3.in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready: got %0b expected 1", b3.in_ready);
    end
    checks++;
    if (b5.out_data !== 8'h00) begin
      failures++; $display("FAIL reset_default_val: got %0h expected 0", b5.out_data);
    end
    #1;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_latency_throughput;
    int acc, em;
    b3.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      b3.in_valid = (i < 6);
      b3.in_data  = (i < 6) ? 8'(i + 1) : 8'h00;
      #1;
      checks++;
      if (b3.out_valid !== ((i >= 3) && (i <= 8))) begin
        failures++; $display("FAIL lat_out_valid[%0d]: got %0b expected %0b", i, b3.out_valid, (i >= 3) && (i <= 8));
      end
      if ((i >= 3) && (i <= 8)) begin
        checks++;
        if (b3.out_data !== 8'(i - 2)) begin
          failures++; $display("FAIL lat_out_data[%0d]: got %0h expected %0h", i, b3.out_data, 8'(i - 2));
        end
      end
      if (i < 6) begin
        checks++;
        if (b3.in_ready !== 1'b1) begin
          failures++; $display("FAIL lat_in_ready[%0d]: got %0b expected 1", i, b3.in_ready);
        end
      end
      acc = (i < 6) ? i : 6;
      em  = (i < 3) ? 0 : ((i - 3 > 6) ? 6 : i - 3);
      checks++;
      if (int'(b3.count) !== acc - em) begin
        failures++; $display("FAIL lat_count[%0d]: got %0d expected %0d", i, b3.count, acc - em);
      end
      tick();
    end
  endtask

  task automatic test_fill_stall;
    logic [7:0] drain [3];
    drain[0] = 8'h22; drain[1] = 8'h33; drain[2] = 8'h44;
    b3.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b3.in_valid = 1'b1;
      b3.in_data  = 8'(8'h11 * (i + 1));
      tick();
    end
    b3.in_valid = 1'b0;
    #1;
    checks++;
    if (b3.count !== 2'd3) begin
      failures++; $display("FAIL full_count: got %0d expected 3", b3.count);
    end
    checks++;
    if (b3.in_ready !== 1'b0) begin
      failures++; $display("FAIL full_in_ready: got %0b expected 0", b3.in_ready);
    end
    checks++;
    if (b3.out_data !== 8'h11 || b3.out_valid !== 1'b1) begin
      failures++; $display("FAIL full_out: got %0h/%0b expected 11/1", b3.out_data, b3.out_valid);
    end
    b3.out_ready = 1'b1; b3.in_valid = 1'b1; b3.in_data = 8'h44;
    #1;
    checks++;
    if (b3.in_ready !== 1'b1) begin
      failures++; $display("FAIL full_release_in_ready: got %0b expected 1", b3.in_ready);
    end
    tick();
    b3.in_valid = 1'b0; b3.out_ready = 1'b0;
    #1;
    checks++;
    if (b3.count !== 2'd3) begin
      failures++; $display("FAIL full_swap_count: got %0d expected 3", b3.count);
    end
    b3.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (b3.out_valid !== 1'b1 || b3.out_data !== drain[i]) begin
        failures++; $display("FAIL full_drain[%0d]: got %0h/%0b expected %0h/1", i, b3.out_data, b3.out_valid, drain[i]);
      end
      tick();
    end
    checks++;
    if (b3.count !== 2'd0) begin
      failures++; $display("FAIL full_drain_count: got %0d expected 0", b3.count);
    end
  endtask

  task automatic test_bubble_collapse;
    b3.out_ready = 1'b0;
    b3.in_valid = 1'b1; b3.in_data = 8'h11;
    tick();
    b3.in_valid = 1'b0;
    tick();
    b3.in_valid = 1'b1; b3.in_data = 8'h22;
    tick();
    b3.in_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (b3.count !== 2'd2 || b3.out_data !== 8'h11 || b3.out_valid !== 1'b1) begin
      failures++; $display("FAIL bubble_settle: got cnt=%0d out=%0h/%0b expected 2 11/1", b3.count, b3.out_data, b3.out_valid);
    end
    b3.out_ready = 1'b1;
    #1;
    tick();
    checks++;
    if (b3.out_valid !== 1'b1 || b3.out_data !== 8'h22) begin
      failures++; $display("FAIL bubble_second: got %0h/%0b expected 22/1", b3.out_data, b3.out_valid);
    end
    tick();
    checks++;
    if (b3.out_valid !== 1'b0 || b3.count !== 2'd0) begin
      failures++; $display("FAIL bubble_empty: got %0b cnt=%0d expected 0 0", b3.out_valid, b3.count);
    end
  endtask

  task automatic test_flush;
    b3.out_ready = 1'b0;
    b3.in_valid = 1'b1; b3.in_data = 8'hAA;
    tick();
    b3.in_data = 8'hBB;
    tick();
    b3.in_valid = 1'b0;
    tick();
    checks++;
    if (b3.count !== 2'd2 || b3.out_valid !== 1'b1) begin
      failures++; $display("FAIL flush_pre: got cnt=%0d ov=%0b expected 2 1", b3.count, b3.out_valid);
    end
    b3.flush = 1'b1; b3.in_valid = 1'b1; b3.in_data = 8'hCC; b3.out_ready = 1'b1;
    #1;
    checks++;
    if (b3.out_valid !== 1'b0) begin
      failures++; $display("FAIL flush_out_valid: got %0b expected 0", b3.out_valid);
    end
    checks++;
    if (b3.in_ready !== 1'b0) begin
      failures++; $display("FAIL flush_in_ready: got %0b expected 0", b3.in_ready);
    end
    tick();
    b3.flush = 1'b0; b3.in_valid = 1'b0; b3.out_ready = 1'b0;
    #1;
    checks++;
    if (b3.count !== 2'd0) begin
      failures++; $display("FAIL flush_count: got %0d expected 0", b3.count);
    end
    checks++;
    if (b3.out_data !== 8'hA5) begin
      failures++; $display("FAIL flush_out_data: got %0h expected a5", b3.out_data);
    end
    b3.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (b3.out_valid !== 1'b0) begin
        failures++; $display("FAIL flush_word_taken[%0d]: got out_valid %0b expected 0", i, b3.out_valid);
      end
    end
  endtask

  task automatic test_random_scoreboard;
    logic [7:0] q1 [$];
    logic [7:0] q5 [$];
    bit held1 = 1'b0;
    bit held5 = 1'b0;
    for (int c = 0; c < 2012; c++) begin
      if (!held1) begin
        b1.in_valid = (c < 2000) && ($urandom_range(0, 3) != 0);
        b1.in_data  = 8'($urandom);
      end
      if (!held5) begin
        b5.in_valid = (c < 2000) && ($urandom_range(0, 3) != 0);
        b5.in_data  = 8'($urandom);
      end
      b1.out_ready = (c >= 2000) || ($urandom_range(0, 3) != 0);
      b5.out_ready = (c >= 2000) || ($urandom_range(0, 1) != 0);
      #1;
      checks++;
      if (int'(b1.count) !== q1.size()) begin
        failures++; $display("FAIL rnd1_count[%0d]: got %0d expected %0d", c, b1.count, q1.size());
      end
      checks++;
      if (int'(b5.count) !== q5.size()) begin
        failures++; $display("FAIL rnd5_count[%0d]: got %0d expected %0d", c, b5.count, q5.size());
      end
      if (b1.out_valid === 1'b1 && b1.out_ready) begin
        checks++;
        if (q1.size() == 0) begin
          failures++; $display("FAIL rnd1_spurious[%0d]: got %0h expected no word", c, b1.out_data);
        end else begin
          if (b1.out_data !== q1[0]) begin
            failures++; $display("FAIL rnd1_data[%0d]: got %0h expected %0h", c, b1.out_data, q1[0]);
          end
          void'(q1.pop_front());
        end
      end
      if (b5.out_valid === 1'b1 && b5.out_ready) begin
        checks++;
        if (q5.size() == 0) begin
          failures++; $display("FAIL rnd5_spurious[%0d]: got %0h expected no word", c, b5.out_data);
        end else begin
          if (b5.out_data !== q5[0]) begin
            failures++; $display("FAIL rnd5_data[%0d]: got %0h expected %0h", c, b5.out_data, q5[0]);
          end
          void'(q5.pop_front());
        end
      end
      if (b1.in_valid && b1.in_ready === 1'b1) q1.push_back(b1.in_data);
      if (b5.in_valid && b5.in_ready === 1'b1) q5.push_back(b5.in_data);
      held1 = b1.in_valid && (b1.in_ready !== 1'b1);
      held5 = b5.in_valid && (b5.in_ready !== 1'b1);
      tick();
    end
    checks++;
    if (q1.size() != 0 || q5.size() != 0) begin
      failures++; $display("FAIL rnd_leftover: got %0d/%0d words outstanding expected 0/0", q1.size(), q5.size());
    end
  endtask

  initial begin
    b3.flush = 1'b0; b3.in_valid = 1'b0; b3.in_data = '0; b3.out_ready = 1'b0;
    b1.flush = 1'b0; b1.in_valid = 1'b0; b1.in_data = '0; b1.out_ready = 1'b0;
    b5.flush = 1'b0; b5.in_valid = 1'b0; b5.in_data = '0; b5.out_ready = 1'b0;
    #12;
    rst = 1'b0;
    test_reset();
    test_latency_throughput();
    test_fill_stall();
    test_bubble_collapse();
    test_flush();
    test_random_scoreboard();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
